group_update_sequencer: RTL and testbench
=========================================

# group_update_sequencer

Drives the 3-bit group select of the grouped update-order LUT in the 4-bit integer-factorization p-computer. It steps through update groups 0..3 in order and holds each one for a programmable number of clocks so the enabled p-bits can settle. An optional dead gap between groups keeps consecutive groups from overlapping. The block counts completed sweeps and stops after a requested number of sweeps, or free-runs.

## Interface
Parameters:
- NUM_GROUPS, 4: groups per sweep; legal group codes are 0..NUM_GROUPS-1.
- GROUP_W, 3: width of group_EN.
- HOLD_CYCLES, 8: clocks each group is enabled; must be ≥1.
- GAP_CYCLES, 1: clocks with no group valid after each group; 0 is legal.
- SWEEP_W, 16: width of the sweep counter and of num_sweeps.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin; honoured only in IDLE.
- stop  in  1  graceful abort request.
- num_sweeps  in  SWEEP_W  sweep budget, sampled with start; 0 means free-run.
- group_EN  out  [0:GROUP_W-1]  current group code; always in 0..NUM_GROUPS-1.
- group_valid  out  1  high only in hold cycles; downstream gates the Pbit_EN mask with it.
- sweep_done  out  1  one-cycle pulse per completed sweep.
- sweep_count  out  SWEEP_W  completed sweeps since start; saturates at all-ones.
- done  out  1  one-cycle pulse when the run ends (budget reached or stop).
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, HOLD, GAP, DONE.
- **IDLE**
  - start=1 and stop=0: latch num_sweeps, clear sweep_count, load group 0, go to HOLD.
  - start=1 and stop=1 in the same cycle: stop wins; remain in IDLE.
- **HOLD**
  - group_valid=1 for exactly HOLD_CYCLES clocks.
  - Then: if GAP_CYCLES>0, go to GAP; otherwise advance directly.
- **GAP**
  - group_valid=0 for GAP_CYCLES clocks.
  - group_EN already shows the next group code.
- **Advance**
  - group = (group+1) mod NUM_GROUPS.
  - Wrap from NUM_GROUPS-1 to 0 completes a sweep: sweep_count increments, sweep_done pulses.
- **Termination**
  - If the latched budget is non-zero and the incremented count equals it, skip the gap and go to DONE.
  - In the same cycle as that final sweep_done, done pulses and group_valid=0.
  - DONE lasts one cycle, then the FSM returns to IDLE.
- **stop in HOLD or GAP**
  - Latched into a pending flag.
  - The current group finishes its full hold; the FSM then goes to DONE without starting another group.
  - A partial sweep does not increment sweep_count.
- start while busy is ignored.
- group_EN never takes codes ≥ NUM_GROUPS; the LUT is undefined for them.
- sweep_count holds its last value in IDLE until the next accepted start.

## Timing
- Reset values: group_EN=0, group_valid=0, sweep_done=0, sweep_count=0, done=0, busy=0, state IDLE, stop-pending cleared.
- Reset is asynchronous, so outputs return to reset values immediately, including mid-run.
- Cycle numbering: start is sampled high in cycle 0.
  - Group g is valid in cycles 1+g·P … HOLD_CYCLES+g·P, where P = HOLD_CYCLES+GAP_CYCLES.
  - Sweep period is NUM_GROUPS·P.
- sweep_done asserts in the cycle after the last hold cycle of group NUM_GROUPS-1; sweep_count updates in that same cycle.
- busy drops the cycle after done.
- Latency from start to first valid group is 1 cycle.

## Structure
- Shared package group_seq_pkg holds:
  - state enum typedef (IDLE, HOLD, GAP, DONE);
  - NUM_GROUPS and GROUP_W constants, shared with the update-order LUT.
- One sub-module, hold_timer: a loadable down-counter with a zero flag. It serves both the hold and gap phases.
- The FSM, group counter and sweep counter live in the top module.

## Test plan
- HOLD=4, GAP=1, num_sweeps=2, start in cycle 0 -> group_valid in cycles 1–4, 6–9, 11–14, 16–19 with group_EN 0,1,2,3; sweep_done in cycles 20 and 40; sweep_count 1 then 2; done in cycle 40; busy=0 in cycle 41.
- GAP=0, HOLD=1, num_sweeps=0, run 100 cycles -> group_EN cycles 0,1,2,3 every clock with group_valid continuously 1; sweep_done every 4th cycle; done never asserted.
- stop asserted in cycle 7 of the first scenario -> group 1 completes in cycle 9; done in cycle 10; sweep_count stays 0; no group 2 ever valid.
- start and stop together in IDLE -> busy stays 0; all outputs at reset values.
- rst_n pulled low in cycle 12 mid-run -> group_valid=0, group_EN=0, sweep_count=0 within the same cycle; a new start after reset release begins again at group 0.
- SWEEP_W=2, free-run for 5 sweeps -> sweep_count saturates at 3 while sweep_done keeps pulsing.

Source files
------------

// File: rtl/group_seq_pkg.sv
// Shared definitions for the grouped update-order sequencer and the update-order LUT.
package group_seq_pkg;

  localparam int NUM_GROUPS = 4;
  localparam int GROUP_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter shared by the hold and gap phases; zero marks the last cycle of a phase.
module hold_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/group_update_sequencer.sv
// Steps the update-order LUT group select through 0..NUM_GROUPS-1 with hold/gap timing,
// counting completed sweeps and ending on a sweep budget or a graceful stop.
module group_update_sequencer #(
  parameter int NUM_GROUPS  = group_seq_pkg::NUM_GROUPS,
  parameter int GROUP_W     = group_seq_pkg::GROUP_W,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int SWEEP_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [0:GROUP_W-1] group_EN,
  output logic               group_valid,
  output logic               sweep_done,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               done,
  output logic               busy
);

  import group_seq_pkg::*;

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0]      HOLD_LD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]      GAP_LD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GROUP_W-1:0] LAST_GRP = GROUP_W'(NUM_GROUPS - 1);

  function automatic logic [SWEEP_W-1:0] sat_inc(input logic [SWEEP_W-1:0] v);
    return (&v) ? v : v + SWEEP_W'(1);
  endfunction

  seq_state_e         state_q, state_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic [SWEEP_W-1:0] count_q, count_d;
  logic [SWEEP_W-1:0] budget_q, budget_d;
  logic               pend_q, pend_d;
  logic               swdone_q, swdone_d;
  logic               tload, tzero, wrap;
  logic [TW-1:0]      tval;
  logic [SWEEP_W-1:0] cnt_inc;

  hold_timer #(.CNT_W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  always_comb begin
    state_d  = state_q;
    group_d  = group_q;
    count_d  = count_q;
    budget_d = budget_q;
    pend_d   = pend_q;
    swdone_d = 1'b0;
    tload    = 1'b0;
    tval     = HOLD_LD;
    wrap     = (group_q == LAST_GRP);
    cnt_inc  = sat_inc(count_q);
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start && !stop) begin
          budget_d = num_sweeps;
          count_d  = '0;
          group_d  = '0;
          tload    = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (stop) pend_d = 1'b1;
        if (tzero) begin
          // Group is advanced on every hold exit so the gap already shows the next code.
          group_d = wrap ? '0 : group_q + GROUP_W'(1);
          if (wrap) begin
            count_d  = cnt_inc;
            swdone_d = 1'b1;
          end
          if ((wrap && budget_q != '0 && cnt_inc == budget_q) || pend_q || stop) begin
            state_d = DONE;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            tload   = 1'b1;
            tval    = GAP_LD;
          end else begin
            state_d = HOLD;
            tload   = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = DONE;
        end else if (tzero) begin
          state_d = HOLD;
          tload   = 1'b1;
        end
      end
      DONE: begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      group_q  <= '0;
      count_q  <= '0;
      budget_q <= '0;
      pend_q   <= 1'b0;
      swdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      group_q  <= group_d;
      count_q  <= count_d;
      budget_q <= budget_d;
      pend_q   <= pend_d;
      swdone_q <= swdone_d;
    end
  end

  assign group_EN    = group_q;
  assign group_valid = (state_q == HOLD);
  assign sweep_done  = swdone_q;
  assign sweep_count = count_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_group_update_sequencer.sv
// Scoreboard bench: instance A (HOLD=4, GAP=1) for budgeted runs, stop and reset;
// instance B (HOLD=1, GAP=0, SWEEP_W=2) for free-run and sweep-count saturation.
module tb_group_update_sequencer;

  localparam int NG = 4;
  localparam int AH = 4, AP = 5;
  localparam int BH = 1, BP = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        a_start = 1'b0, a_stop = 1'b0;
  logic [15:0] a_num = '0;
  logic [0:2]  a_grp;
  logic        a_valid, a_sd, a_done, a_busy;
  logic [15:0] a_cnt;

  logic        b_start = 1'b0, b_stop = 1'b0;
  logic [1:0]  b_num = '0;
  logic [0:2]  b_grp;
  logic        b_valid, b_sd, b_done, b_busy;
  logic [1:0]  b_cnt;

  group_update_sequencer #(
    .NUM_GROUPS(4), .GROUP_W(3), .HOLD_CYCLES(AH), .GAP_CYCLES(1), .SWEEP_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .num_sweeps(a_num),
    .group_EN(a_grp), .group_valid(a_valid), .sweep_done(a_sd), .sweep_count(a_cnt),
    .done(a_done), .busy(a_busy)
  );

  group_update_sequencer #(
    .NUM_GROUPS(4), .GROUP_W(3), .HOLD_CYCLES(BH), .GAP_CYCLES(0), .SWEEP_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .num_sweeps(b_num),
    .group_EN(b_grp), .group_valid(b_valid), .sweep_done(b_sd), .sweep_count(b_cnt),
    .done(b_done), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t qv[$];
  ev_t qs[$];
  ev_t qd[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected event timeline: group i of the run is valid in cycles 1+i*p .. h+i*p,
  // a sweep completes the cycle after each group NG-1 hold ends.
  task automatic push_run(input int h, input int p, input int satmax, input int ngroups,
                          input int done_cyc, input int n);
    int g, sc, cn;
    qv.delete(); qs.delete(); qd.delete();
    for (int i = 0; i < ngroups; i++) begin
      g = i % NG;
      for (int k = 0; k < h; k++)
        if (1 + i*p + k <= n) qv.push_back('{1 + i*p + k, g});
      sc = i*p + h + 1;
      cn = ((i + 1) / NG > satmax) ? satmax : (i + 1) / NG;
      if (g == NG-1 && sc <= n) qs.push_back('{sc, cn});
    end
    if (done_cyc > 0) qd.push_back('{done_cyc, 1});
  endtask

  task automatic start_run(input int which, input int num);
    @(negedge clk);
    if (which == 0) begin a_start = 1'b1; a_num = 16'(num); end
    else begin b_start = 1'b1; b_num = 2'(num); end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic monitor(input int which, input int n, input int done_cyc, input int stop_at);
    logic        v, sd, dn, bz, ev, es, ed, eb;
    logic [31:0] g, cnt;
    ev_t         e;
    for (int c = 1; c <= n; c++) begin
      if (which == 0) begin
        v = a_valid; g = 32'(a_grp); sd = a_sd; cnt = 32'(a_cnt); dn = a_done; bz = a_busy;
      end else begin
        v = b_valid; g = 32'(b_grp); sd = b_sd; cnt = 32'(b_cnt); dn = b_done; bz = b_busy;
      end
      ev = (qv.size() > 0) && (qv[0].cyc == c);
      es = (qs.size() > 0) && (qs[0].cyc == c);
      ed = (qd.size() > 0) && (qd[0].cyc == c);
      eb = (done_cyc == 0) || (c <= done_cyc);
      chk($sformatf("valid@%0d", c), 32'(v), 32'(ev));
      if (ev) begin e = qv.pop_front(); chk($sformatf("group@%0d", c), g, 32'(e.val)); end
      chk($sformatf("sweep_done@%0d", c), 32'(sd), 32'(es));
      if (es) begin e = qs.pop_front(); chk($sformatf("sweep_count@%0d", c), cnt, 32'(e.val)); end
      chk($sformatf("done@%0d", c), 32'(dn), 32'(ed));
      if (ed) void'(qd.pop_front());
      chk($sformatf("busy@%0d", c), 32'(bz), 32'(eb));
      if (which == 0) a_stop = (c == stop_at);
      else b_stop = (c == stop_at);
      if (c < n) @(negedge clk);
    end
    a_stop = 1'b0;
    b_stop = 1'b0;
    chk("valid_events_left", 32'(qv.size()), 0);
    chk("sweep_events_left", 32'(qs.size()), 0);
    chk("done_events_left", 32'(qd.size()), 0);
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_valid"}, 32'(a_valid), 0);
    chk({tag, "_group"}, 32'(a_grp), 0);
    chk({tag, "_sweep_done"}, 32'(a_sd), 0);
    chk({tag, "_count"}, 32'(a_cnt), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
  endtask

  initial begin
    logic seen;
    #1 rst_n = 1'b0;
    #1;
    chk_a_reset("reset");
    chk("reset_b_valid", 32'(b_valid), 0);
    chk("reset_b_busy", 32'(b_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start and stop together in IDLE: stop wins
    a_start = 1'b1; a_stop = 1'b1; a_num = 16'd2;
    @(negedge clk);
    a_start = 1'b0; a_stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_a_reset("start_stop");
      @(negedge clk);
    end

    // two-sweep budgeted run
    push_run(AH, AP, 65535, 8, 40, 45);
    start_run(0, 2);
    monitor(0, 45, 40, -1);
    chk("count_held_idle", 32'(a_cnt), 2);

    // stop during group 1
    push_run(AH, AP, 65535, 2, 10, 14);
    start_run(0, 2);
    monitor(0, 14, 10, 7);
    chk("stop_count", 32'(a_cnt), 0);

    // asynchronous reset mid-run in cycle 12
    push_run(AH, AP, 65535, 3, 0, 12);
    start_run(0, 0);
    monitor(0, 12, 0, -1);
    rst_n = 1'b0;
    #1;
    chk_a_reset("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // restart after reset, one-sweep budget
    push_run(AH, AP, 65535, 4, 20, 22);
    start_run(0, 1);
    monitor(0, 22, 20, -1);

    // free-run with back-to-back groups and saturating 2-bit sweep count
    push_run(BH, BP, 3, 100, 0, 100);
    start_run(1, 0);
    monitor(1, 100, 0, -1);
    b_stop = 1'b1;
    @(negedge clk);
    b_stop = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (b_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("b_done_after_stop", 32'(seen), 1);
    chk("b_count_saturated", 32'(b_cnt), 3);
    @(negedge clk);
    chk("b_busy_after_done", 32'(b_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
